axi_sram_slave: RTL
===================

// Module: axi_sram_slave
// PURPOSE
// AXI4 slave responder at the far end of a crossbar slave port (S1..S5): accepts AR/R and AW/W/B bursts
// from the crossbar master interface and drives one single-port word SRAM macro. Serves one burst at a
// time (read or write), INCR addressing, OKAY/SLVERR responses. Single clock domain (the slave's clock).
// PARAMETERS
// ID_BITS    8   width of ARID/RID/AWID/BID (crossbar-extended ID)
// ADDR_BITS  32  AXI address width
// DATA_BITS  32  data width; STRB = DATA_BITS/8
// LEN_BITS   4   AxLEN width; burst = AxLEN+1 beats (1..16)
// MEM_AW     14  SRAM word-address width (depth 2**MEM_AW words)
// PORTS
// SRAM_CLK_i   in   1          clock
// SRAM_RST_i   in   1          synchronous reset, active-low
// ARID_i/ARADDR_i/ARLEN_i/ARSIZE_i/ARBURST_i  in  ID/ADDR/LEN/3/2  read address channel payload
// ARVALID_i    in   1          | ARREADY_o  out  1   read address handshake
// RID_o        out  ID_BITS    | RDATA_o  out  DATA_BITS | RRESP_o  out  2 | RLAST_o  out  1
// RVALID_o     out  1          | RREADY_i  in  1     read data handshake
// AWID_i/AWADDR_i/AWLEN_i/AWSIZE_i/AWBURST_i  in  ID/ADDR/LEN/3/2  write address channel payload
// AWVALID_i    in   1          | AWREADY_o  out  1
// WDATA_i      in   DATA_BITS  | WSTRB_i  in  STRB | WLAST_i  in  1 | WVALID_i  in  1 | WREADY_o  out  1
// BID_o        out  ID_BITS    | BRESP_o  out  2 | BVALID_o  out  1 | BREADY_i  in  1
// MEM_CS_o     out  1          SRAM chip select (access this cycle)
// MEM_WEB_o    out  STRB       per-byte write enable, 1 = write byte
// MEM_A_o      out  MEM_AW     SRAM word address
// MEM_DI_o     out  DATA_BITS  SRAM write data
// MEM_DO_i     in   DATA_BITS  SRAM read data; valid cycle after a read CS, held until next CS
// BEHAVIOUR
// - Reset (SRAM_RST_i=0 at edge): state IDLE, all *VALID_o/*READY_o/MEM_CS_o/MEM_WEB_o = 0, IDs/data/RESP 0,
//   rd_prio=1; any in-flight burst is dropped with no further beats or B response.
// - FSM: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
// - IDLE: ARREADY_o = ARVALID_i & (~AWVALID_i | rd_prio); AWREADY_o = AWVALID_i & (~ARVALID_i | ~rd_prio).
//   Both valid: grant by rd_prio, then rd_prio toggles. AR hs -> RD_REQ; AW hs -> WR_DATA.
//   On hs latch id, word addr = AxADDR[MEM_AW+1:2], len; beat counter = 0. AxSIZE/AxBURST ignored (word INCR).
// - RD_REQ (1 cycle): MEM_CS_o=1, MEM_WEB_o=0, MEM_A_o=addr -> RD_DATA.
// - RD_DATA: RVALID_o=1, RDATA_o=MEM_DO_i, RID_o=latched id, RRESP_o=2'b00, RLAST_o=(cnt==len).
//   Payload stable while RVALID_o & ~RREADY_i. On RREADY_i: last -> IDLE, else addr+1, cnt+1 -> RD_REQ.
//   Latency: AR hs at T -> first RVALID_o at T+2; one beat per 2 cycles at most.
// - WR_DATA: WREADY_o=1; on WVALID_i: same cycle MEM_CS_o=1, MEM_WEB_o=WSTRB_i, MEM_A_o=addr, MEM_DI_o=WDATA_i;
//   addr+1, cnt+1. Burst ends on beat cnt==len (WLAST_i not used for termination) -> WR_RESP.
//   err flag set if WLAST_i=1 on a non-final beat or WLAST_i=0 on the final beat.
// - WR_RESP: BVALID_o=1, BID_o=latched id, BRESP_o = err ? 2'b10 (SLVERR) : 2'b00; held until BREADY_i -> IDLE.
// - Word address increments modulo 2**MEM_AW (wraps 2**MEM_AW-1 -> 0). Upper address bits ignored.
// - MEM_CS_o=0 in every cycle not listed above; no SRAM access in IDLE or WR_RESP.
// TESTING
// 1 Single write AW(id=8'h15,addr=0x100,len=0), W(0xDEADBEEF,strb=4'hF,last=1) -> MEM A=0x40 written; B id=0x15 resp=00.
// 2 Read burst AR(id=8'h22,addr=0x100,len=3) after writing 0x40..0x43 -> 4 beats, RLAST only on 4th, first RVALID at T+2.
// 3 RREADY held low 5 cycles on beat 1 -> RDATA/RID/RLAST stable, no extra MEM_CS_o pulses.
// 4 ARVALID & AWVALID same cycle twice after reset -> read granted first, write second; rd_prio alternates.
// 5 Write len=1 with WLAST=1 on beat 0 -> two SRAM writes, BRESP=2'b10; WSTRB=4'b0101 updates bytes 0,2 only.
// 6 Burst at word 2**MEM_AW-2, len=3 -> addresses wrap to 0,1; reset asserted mid-read -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 slave that serves one INCR burst at a time from a single-port word SRAM.
// Reads take one SRAM request cycle plus one data cycle per beat; writes hit the SRAM in the W handshake cycle.
module axi_sram_slave #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int MEM_AW    = 14
) (
    input  logic                   SRAM_CLK_i,
    input  logic                   SRAM_RST_i,
    input  logic [ID_BITS-1:0]     ARID_i,
    input  logic [ADDR_BITS-1:0]   ARADDR_i,
    input  logic [LEN_BITS-1:0]    ARLEN_i,
    input  logic [2:0]             ARSIZE_i,
    input  logic [1:0]             ARBURST_i,
    input  logic                   ARVALID_i,
    output logic                   ARREADY_o,
    output logic [ID_BITS-1:0]     RID_o,
    output logic [DATA_BITS-1:0]   RDATA_o,
    output logic [1:0]             RRESP_o,
    output logic                   RLAST_o,
    output logic                   RVALID_o,
    input  logic                   RREADY_i,
    input  logic [ID_BITS-1:0]     AWID_i,
    input  logic [ADDR_BITS-1:0]   AWADDR_i,
    input  logic [LEN_BITS-1:0]    AWLEN_i,
    input  logic [2:0]             AWSIZE_i,
    input  logic [1:0]             AWBURST_i,
    input  logic                   AWVALID_i,
    output logic                   AWREADY_o,
    input  logic [DATA_BITS-1:0]   WDATA_i,
    input  logic [DATA_BITS/8-1:0] WSTRB_i,
    input  logic                   WLAST_i,
    input  logic                   WVALID_i,
    output logic                   WREADY_o,
    output logic [ID_BITS-1:0]     BID_o,
    output logic [1:0]             BRESP_o,
    output logic                   BVALID_o,
    input  logic                   BREADY_i,
    output logic                   MEM_CS_o,
    output logic [DATA_BITS/8-1:0] MEM_WEB_o,
    output logic [MEM_AW-1:0]      MEM_A_o,
    output logic [DATA_BITS-1:0]   MEM_DI_o,
    input  logic [DATA_BITS-1:0]   MEM_DO_i
);

    localparam int STRB_BITS = DATA_BITS / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t              state_r;
    logic [ID_BITS-1:0]  id_r;
    logic [MEM_AW-1:0]   addr_r;
    logic [LEN_BITS-1:0] len_r;
    logic [LEN_BITS-1:0] cnt_r;
    logic                rd_prio_r;
    logic                err_r;
    logic                rvalid_r;
    logic                rlast_r;
    logic                rd_cs_r;
    logic                wready_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;

    logic                arready_s;
    logic                awready_s;
    logic                ar_hs_s;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                last_beat_s;
    logic                err_next_s;

    // Size, burst type, byte offset and upper address bits carry no meaning for a word-INCR SRAM.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{ARSIZE_i, ARBURST_i, AWSIZE_i, AWBURST_i,
                               ARADDR_i[ADDR_BITS-1:MEM_AW+2], ARADDR_i[1:0],
                               AWADDR_i[ADDR_BITS-1:MEM_AW+2], AWADDR_i[1:0]};

    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a);
        return a + {{(MEM_AW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [LEN_BITS-1:0] next_cnt(input logic [LEN_BITS-1:0] c);
        return c + {{(LEN_BITS-1){1'b0}}, 1'b1};
    endfunction

    // A write beat is malformed when its WLAST disagrees with the beat position.
    function automatic logic wlast_mismatch(input logic last_beat, input logic wlast);
        return last_beat ^ wlast;
    endfunction

    // Address-channel arbitration and write-beat handshake decode.
    always_comb begin
        arready_s = 1'b0;
        awready_s = 1'b0;
        if (SRAM_RST_i && (state_r == IDLE)) begin
            arready_s = ARVALID_i & (~AWVALID_i | rd_prio_r);
            awready_s = AWVALID_i & (~ARVALID_i | ~rd_prio_r);
        end else begin
            arready_s = 1'b0;
            awready_s = 1'b0;
        end
        ar_hs_s     = ARVALID_i & arready_s;
        aw_hs_s     = AWVALID_i & awready_s;
        w_hs_s      = wready_r & WVALID_i;
        last_beat_s = (cnt_r == len_r);
        err_next_s  = err_r | wlast_mismatch(last_beat_s, WLAST_i);
    end

    // Burst sequencer: one read or write burst in flight at a time.
    always_ff @(posedge SRAM_CLK_i) begin
        if (!SRAM_RST_i) begin
            state_r   <= IDLE;
            id_r      <= {ID_BITS{1'b0}};
            addr_r    <= {MEM_AW{1'b0}};
            len_r     <= {LEN_BITS{1'b0}};
            cnt_r     <= {LEN_BITS{1'b0}};
            rd_prio_r <= 1'b1;
            err_r     <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rd_cs_r   <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ARVALID_i && AWVALID_i) begin
                        rd_prio_r <= ~rd_prio_r;
                    end else begin
                        rd_prio_r <= rd_prio_r;
                    end
                    if (ar_hs_s) begin
                        id_r    <= ARID_i;
                        addr_r  <= ARADDR_i[MEM_AW+1:2];
                        len_r   <= ARLEN_i;
                        cnt_r   <= {LEN_BITS{1'b0}};
                        rd_cs_r <= 1'b1;
                        state_r <= RD_REQ;
                    end else if (aw_hs_s) begin
                        id_r     <= AWID_i;
                        addr_r   <= AWADDR_i[MEM_AW+1:2];
                        len_r    <= AWLEN_i;
                        cnt_r    <= {LEN_BITS{1'b0}};
                        err_r    <= 1'b0;
                        wready_r <= 1'b1;
                        state_r  <= WR_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    rd_cs_r  <= 1'b0;
                    rvalid_r <= 1'b1;
                    rlast_r  <= last_beat_s;
                    state_r  <= RD_DATA;
                end
                RD_DATA: begin
                    if (RREADY_i) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                        if (rlast_r) begin
                            state_r <= IDLE;
                        end else begin
                            addr_r  <= next_addr(addr_r);
                            cnt_r   <= next_cnt(cnt_r);
                            rd_cs_r <= 1'b1;
                            state_r <= RD_REQ;
                        end
                    end else begin
                        state_r <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs_s) begin
                        addr_r <= next_addr(addr_r);
                        cnt_r  <= next_cnt(cnt_r);
                        err_r  <= err_next_s;
                        if (last_beat_s) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bresp_r  <= err_next_s ? 2'b10 : 2'b00;
                            state_r  <= WR_RESP;
                        end else begin
                            state_r <= WR_DATA;
                        end
                    end else begin
                        state_r <= WR_DATA;
                    end
                end
                WR_RESP: begin
                    if (BREADY_i) begin
                        bvalid_r <= 1'b0;
                        bresp_r  <= 2'b00;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                default: begin
                    rvalid_r <= 1'b0;
                    rlast_r  <= 1'b0;
                    rd_cs_r  <= 1'b0;
                    wready_r <= 1'b0;
                    bvalid_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Channel outputs; RDATA is a pass-through because the macro holds DO until its next access.
    always_comb begin
        ARREADY_o = arready_s;
        AWREADY_o = awready_s;
        WREADY_o  = wready_r;
        RVALID_o  = rvalid_r;
        RLAST_o   = rlast_r;
        RRESP_o   = 2'b00;
        BVALID_o  = bvalid_r;
        BRESP_o   = bresp_r;
        if (rvalid_r) begin
            RID_o   = id_r;
            RDATA_o = MEM_DO_i;
        end else begin
            RID_o   = {ID_BITS{1'b0}};
            RDATA_o = {DATA_BITS{1'b0}};
        end
        if (bvalid_r) begin
            BID_o = id_r;
        end else begin
            BID_o = {ID_BITS{1'b0}};
        end
    end

    // SRAM port: read request cycle or same-cycle write of an accepted W beat.
    always_comb begin
        MEM_CS_o  = 1'b0;
        MEM_WEB_o = {STRB_BITS{1'b0}};
        MEM_A_o   = {MEM_AW{1'b0}};
        MEM_DI_o  = {DATA_BITS{1'b0}};
        if (rd_cs_r) begin
            MEM_CS_o = 1'b1;
            MEM_A_o  = addr_r;
        end else if (w_hs_s) begin
            MEM_CS_o  = 1'b1;
            MEM_WEB_o = WSTRB_i;
            MEM_A_o   = addr_r;
            MEM_DI_o  = WDATA_i;
        end else begin
            MEM_CS_o = 1'b0;
        end
    end

endmodule
